// File: rtl/internal_bus_pkg.sv
// Shared types and default sizing for the internal bus arbiter.
package internal_bus_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_OWNED = 1'b1
  } arb_state_t;

  localparam int DEF_REQ_COUNT = 4;
  localparam int DEF_MAX_HOLD  = 8;

endpackage

// File: rtl/internal_bus_arbiter_rr_picker.sv
// Round-robin winner search: lowest requesting index at or above ptr, wrapping.
module rr_picker #(
  parameter int REQ_COUNT = 4,
  parameter int ENC_WIDTH = 2
) (
  input  logic [REQ_COUNT-1:0] req,
  input  logic [ENC_WIDTH-1:0] ptr,
  output logic [REQ_COUNT-1:0] grant,
  output logic                 valid
);

  always_comb begin
    int idx;
    grant = '0;
    valid = 1'b0;
    idx   = 0;
    for (int i = 0; i < REQ_COUNT; i++) begin
      idx = (int'(ptr) + i) % REQ_COUNT;
      if (!valid && req[idx]) begin
        grant[idx] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/onehot_encoder.sv
// Generic one-hot to binary index encoder; an all-zero input encodes to 0.
module onehot_encoder #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] onehot,
  output logic [W-1:0] index
);

  always_comb begin
    index = '0;
    for (int i = 0; i < N; i++) begin
      if (onehot[i]) index = index | W'(i);
    end
  end

endmodule

// File: rtl/internal_bus_arbiter.sv
// Round-robin arbiter with owner lock for a shared internal bus.
// Define BUS_ARB_TIMEOUT_EN to bound lock duration to MAX_HOLD cycles.
module internal_bus_arbiter
  import internal_bus_pkg::*;
#(
  parameter int REQ_COUNT = DEF_REQ_COUNT,
  parameter int ENC_WIDTH = $clog2(REQ_COUNT),
  parameter int MAX_HOLD  = DEF_MAX_HOLD
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic [REQ_COUNT-1:0] req,
  input  logic [REQ_COUNT-1:0] lock,
  output logic [REQ_COUNT-1:0] busSelect,
  output logic [ENC_WIDTH-1:0] owner,
  output logic                 busy,
  output logic                 timeout
);

  arb_state_t           state_reg, state_next;
  logic [REQ_COUNT-1:0] grant_reg, grant_next;
  logic [ENC_WIDTH-1:0] ptr_reg, ptr_next;
  logic [REQ_COUNT-1:0] arb_req, pick_grant;
  logic [ENC_WIDTH-1:0] pick_idx;
  logic                 pick_valid;
  logic                 held, expire, keep;

  assign held = |(grant_reg & req & lock);

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_HOLD) + 1;
  logic [CNT_W-1:0] hold_cnt_reg;
  logic             timeout_reg;

  assign expire = held && (hold_cnt_reg == CNT_W'(MAX_HOLD - 1));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      hold_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      hold_cnt_reg <= keep ? hold_cnt_reg + CNT_W'(1) : '0;
      timeout_reg  <= (state_reg == ARB_OWNED) && expire;
    end
  end

  assign timeout = timeout_reg;
`else
  logic unused_max_hold;
  assign unused_max_hold = (MAX_HOLD > 0);
  assign expire          = 1'b0;
  assign timeout         = 1'b0;
`endif

  // ptr always sits just past the owner, so the owner naturally ranks last;
  // only a forced revoke needs to remove it from the candidate set.
  assign arb_req = expire ? (req & ~grant_reg) : req;

  rr_picker #(
    .REQ_COUNT(REQ_COUNT),
    .ENC_WIDTH(ENC_WIDTH)
  ) u_picker (
    .req  (arb_req),
    .ptr  (ptr_reg),
    .grant(pick_grant),
    .valid(pick_valid)
  );

  onehot_encoder #(.N(REQ_COUNT), .W(ENC_WIDTH)) u_pick_enc (
    .onehot(pick_grant),
    .index (pick_idx)
  );

  onehot_encoder #(.N(REQ_COUNT), .W(ENC_WIDTH)) u_owner_enc (
    .onehot(grant_reg),
    .index (owner)
  );

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    ptr_next   = ptr_reg;
    keep       = (state_reg == ARB_OWNED) && held && !expire;
    if (!keep) begin
      if (pick_valid) begin
        state_next = ARB_OWNED;
        grant_next = pick_grant;
        ptr_next   = (pick_idx == ENC_WIDTH'(REQ_COUNT - 1)) ? '0 : pick_idx + ENC_WIDTH'(1);
      end else begin
        state_next = ARB_IDLE;
        grant_next = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg <= ARB_IDLE;
      grant_reg <= '0;
      ptr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      ptr_reg   <= ptr_next;
    end
  end

  assign busSelect = grant_reg;
  assign busy      = |grant_reg;

endmodule

// File: tb/tb_internal_bus_arbiter.sv
// Directed-table and randomized bench for internal_bus_arbiter (REQ_COUNT=4).
module tb_internal_bus_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         nrst = 1'b0;
  logic [N-1:0] req = '0;
  logic [N-1:0] lock = '0;
  logic [N-1:0] sel;
  logic [1:0]   owner;
  logic         busy;
  logic         timeout;

  internal_bus_arbiter #(.REQ_COUNT(N), .MAX_HOLD(8)) dut (
    .clk      (clk),
    .nrst     (nrst),
    .req      (req),
    .lock     (lock),
    .busSelect(sel),
    .owner    (owner),
    .busy     (busy),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] lock;
    logic [N-1:0] sel;
    logic [1:0]   own;
    logic         busy;
  } vec_t;

  vec_t vecs[22];
  int   checks = 0;
  int   failures = 0;
  int   wait_cnt[N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] enc(input logic [N-1:0] oh);
    logic [1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) if (oh[i]) r = 2'(i);
    return r;
  endfunction

  initial begin
    // Sequence from reset; ptr evolution noted at the right of each record.
    vecs[0]  = '{4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1}; // ptr 3
    vecs[1]  = '{4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0};
    vecs[2]  = '{4'b1111, 4'b0000, 4'b1000, 2'd3, 1'b1}; // ptr 0
    vecs[3]  = '{4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b1}; // ptr 1
    vecs[4]  = '{4'b1111, 4'b0000, 4'b0010, 2'd1, 1'b1};
    vecs[5]  = '{4'b1111, 4'b0000, 4'b0100, 2'd2, 1'b1};
    vecs[6]  = '{4'b1111, 4'b0000, 4'b1000, 2'd3, 1'b1};
    vecs[7]  = '{4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b1}; // ptr 1
    vecs[8]  = '{4'b1010, 4'b0010, 4'b0010, 2'd1, 1'b1}; // ptr 2
    vecs[9]  = '{4'b1010, 4'b0010, 4'b0010, 2'd1, 1'b1};
    vecs[10] = '{4'b1010, 4'b0010, 4'b0010, 2'd1, 1'b1};
    vecs[11] = '{4'b1010, 4'b0010, 4'b0010, 2'd1, 1'b1};
    vecs[12] = '{4'b1010, 4'b0010, 4'b0010, 2'd1, 1'b1};
    vecs[13] = '{4'b1010, 4'b0010, 4'b0010, 2'd1, 1'b1};
    vecs[14] = '{4'b1010, 4'b0000, 4'b1000, 2'd3, 1'b1}; // ptr 0
    vecs[15] = '{4'b1000, 4'b0001, 4'b1000, 2'd3, 1'b1}; // non-owner lock ignored
    vecs[16] = '{4'b0001, 4'b1000, 4'b0001, 2'd0, 1'b1}; // lock without req ignored, ptr 1
    vecs[17] = '{4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b1}; // owner re-wins when alone
    vecs[18] = '{4'b0110, 4'b0100, 4'b0010, 2'd1, 1'b1}; // ptr 2
    vecs[19] = '{4'b0110, 4'b0110, 4'b0010, 2'd1, 1'b1};
    vecs[20] = '{4'b0100, 4'b0010, 4'b0100, 2'd2, 1'b1}; // ptr 3
    vecs[21] = '{4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0};

    #2;
    check("reset_sel", 32'(sel), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    tick();
    nrst = 1'b1;
    tick();
    check("idle_sel", 32'(sel), 32'd0);
    check("idle_owner", 32'(owner), 32'd0);
    check("idle_timeout", 32'(timeout), 32'd0);

    for (int i = 0; i < 22; i++) begin
      req  = vecs[i].req;
      lock = vecs[i].lock;
      tick();
      check($sformatf("vec%0d_sel", i), 32'(sel), 32'(vecs[i].sel));
      check($sformatf("vec%0d_owner", i), 32'(owner), 32'(vecs[i].own));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
      check($sformatf("vec%0d_timeout", i), 32'(timeout), 32'd0);
      $display("vec %0d req=%b lock=%b sel=%b owner=%0d", i, req, lock, sel, owner);
    end

    // Asynchronous reset mid-grant; without reset ptr=3 would pick 1000.
    req = 4'b0100;
    tick();
    check("pre_rst_sel", 32'(sel), 32'b0100);
    #2 nrst = 1'b0;
    #1;
    check("async_rst_sel", 32'(sel), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_owner", 32'(owner), 32'd0);
    #1 nrst = 1'b1;
    req = 4'b1010;
    tick();
    check("post_rst_sel", 32'(sel), 32'b0010);
    $display("async reset: sel=%b after release", sel);
    req = '0;
    tick();

    // Owner 0 holds lock while requester 2 waits.
    req  = 4'b0001;
    lock = 4'b0001;
    tick();
    check("hold_grant_sel", 32'(sel), 32'b0001);
    req = 4'b0101;
`ifdef BUS_ARB_TIMEOUT_EN
    for (int k = 1; k < 8; k++) begin
      tick();
      check($sformatf("hold%0d_sel", k), 32'(sel), 32'b0001);
      check($sformatf("hold%0d_timeout", k), 32'(timeout), 32'd0);
    end
    tick();
    check("revoke_sel", 32'(sel), 32'b0100);
    check("revoke_timeout", 32'(timeout), 32'd1);
    tick();
    check("revoke_after_timeout", 32'(timeout), 32'd0);
    $display("timeout: revoke observed, sel=%b", sel);
`else
    for (int k = 1; k <= 20; k++) begin
      tick();
      check($sformatf("hold%0d_sel", k), 32'(sel), 32'b0001);
      check($sformatf("hold%0d_timeout", k), 32'(timeout), 32'd0);
    end
    lock = '0;
    tick();
    check("unlock_sel", 32'(sel), 32'b0100);
    $display("lock held 20 cycles, release -> sel=%b", sel);
`endif

    // Random: first phase unlocked with sticky requests for fairness, then random lock.
    lock = '0;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    for (int c = 0; c < 10000; c++) begin
      int worst;
      if (c < 5000) begin
        for (int i = 0; i < N; i++) if ($urandom_range(7) == 0) req[i] = ~req[i];
        lock = '0;
      end else begin
        req  = 4'($urandom_range(15));
        lock = 4'($urandom_range(15));
      end
      tick();
      check("rnd_onehot", 32'($onehot0(sel)), 32'd1);
      check("rnd_owner", 32'(owner), 32'(enc(sel)));
      check("rnd_busy", 32'(busy), 32'(|sel));
`ifndef BUS_ARB_TIMEOUT_EN
      check("rnd_timeout", 32'(timeout), 32'd0);
`endif
      if (c < 5000) begin
        worst = 0;
        for (int i = 0; i < N; i++) begin
          if (req[i] && !sel[i]) wait_cnt[i]++;
          else wait_cnt[i] = 0;
          if (wait_cnt[i] > worst) worst = wait_cnt[i];
        end
        check("rnd_fair", 32'(worst < N), 32'd1);
      end
    end
    $display("random phase: 10000 cycles done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
